wide_stream_arbiter: RTL

- Packet-locked round-robin arbiter that shares one downstream wide-block consumer (result writer / network TX) between NUM_SRC block-shift packer trees. Each tree emits 8*BLOCK_SIZE-bit beats with a block count and a last flag.
- Grant is held from the first beat of a packet until its last beat is accepted, so packets never interleave.
- Sits directly after the packer trees; output is registered.

---
 rtl/wsa_pkg.sv | 21 ++
 rtl/wide_stream_arbiter_rr_pick.sv | 30 +++
 rtl/wide_stream_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/wsa_pkg.sv
// Shared types and constants for the wide-stream arbiter.
// Optional per-source statistics counters are enabled with WSA_STATS_EN.
package wsa_pkg;

    localparam int MAX_BLOCKS_PER_BEAT = 8;
    localparam int DEF_BLOCK_SIZE      = 128;
    localparam int DEF_DATA_W          = MAX_BLOCKS_PER_BEAT * DEF_BLOCK_SIZE;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Beat as produced by a packer tree at the default geometry.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [31:0]           num;
        logic                  last;
    } beat_t;

endpackage

// File: rtl/wide_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_pick
    import wsa_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    int unsigned w_pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        w_pos = 0;
        for (int unsigned i = 0; i < N; i++) begin
            w_pos = (32'(ptr) + i) % N;
            if (!valid && req[w_pos]) begin
                valid = 1'b1;
                idx   = W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/wide_stream_arbiter.sv
// Packet-locked round-robin arbiter feeding one wide-block consumer through
// a registered output stage. WSA_STATS_EN adds per-source packet/block counters.
module wide_stream_arbiter
    import wsa_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int BLOCK_SIZE = 128,
    parameter int DATA_W     = MAX_BLOCKS_PER_BEAT * BLOCK_SIZE,
    parameter int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC-1:0][DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0][31:0]       src_num,
    input  logic [NUM_SRC-1:0]             src_last,
    input  logic                           ready_4_output,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_valid,
    output logic [31:0]                    out_num,
    output logic                           out_last,
    output logic [SRC_W-1:0]               out_src,
    output logic                           busy
`ifdef WSA_STATS_EN
    ,
    output logic [NUM_SRC-1:0][31:0]       stat_pkts,
    output logic [NUM_SRC-1:0][31:0]       stat_blocks
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [31:0]       num;
        logic              last;
    } beat_w_t;

    state_t           r_state;
    logic [SRC_W-1:0] r_rr_ptr;
    logic [SRC_W-1:0] r_grant;
    beat_w_t          r_out;
    logic             r_out_valid;
    logic [SRC_W-1:0] r_out_src;
    logic             r_busy;

    logic             w_pick_valid;
    logic [SRC_W-1:0] w_pick_idx;
    logic             w_out_free;
    logic             w_fire;

    rr_pick #(
        .N (NUM_SRC),
        .W (SRC_W)
    ) u_rr_pick (
        .req   (src_valid),
        .ptr   (r_rr_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_out_free = !r_out_valid || ready_4_output;
    assign w_fire     = (r_state == LOCK) && src_valid[r_grant] && w_out_free;

    // Ready is forced low under reset so upstream never sees a dropped beat as accepted.
    always_comb begin
        src_ready = '0;
        if (!rst && (r_state == LOCK)) begin
            src_ready[r_grant] = w_out_free;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_busy      <= 1'b0;
        end else begin
            if (w_fire) begin
                r_out.data  <= src_data[r_grant];
                r_out.num   <= src_num[r_grant];
                r_out.last  <= src_last[r_grant];
                r_out_src   <= r_grant;
                r_out_valid <= 1'b1;
            end else if (w_out_free) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_state <= LOCK;
                        r_busy  <= 1'b1;
                    end
                end
                LOCK: begin
                    if (w_fire && src_last[r_grant]) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= (r_grant == SRC_W'(NUM_SRC - 1)) ? '0 : r_grant + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = r_out.data;
    assign out_num   = r_out.num;
    assign out_last  = r_out.last;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;
    assign busy      = r_busy;

`ifdef WSA_STATS_EN
    logic [NUM_SRC-1:0][31:0] r_stat_pkts;
    logic [NUM_SRC-1:0][31:0] r_stat_blocks;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_pkts   <= '0;
            r_stat_blocks <= '0;
        end else if (w_fire) begin
            r_stat_blocks[r_grant] <= r_stat_blocks[r_grant] + src_num[r_grant];
            if (src_last[r_grant]) begin
                r_stat_pkts[r_grant] <= r_stat_pkts[r_grant] + 32'd1;
            end
        end
    end

    assign stat_pkts   = r_stat_pkts;
    assign stat_blocks = r_stat_blocks;
`endif

endmodule
